// File: rtl/button_menu_ctrl_if.sv
// rtl/button_menu_ctrl_if.sv - key inputs and menu/threshold outputs of the front-panel menu controller
interface button_menu_ctrl_if #(
    parameter int PAGE_NUM    = 4,
    parameter int VALUE_WIDTH = 8
);
    localparam int PAGE_W = (PAGE_NUM > 1) ? $clog2(PAGE_NUM) : 1;

    logic [1:0]             key_level;
    logic [1:0]             key_edge;
    logic [PAGE_W-1:0]      page;
    logic                   edit_mode;
    logic [VALUE_WIDTH-1:0] edit_value;
    logic [VALUE_WIDTH-1:0] threshold;
    logic                   cfg_valid;

    modport master (
        output key_level, key_edge,
        input  page, edit_mode, edit_value, threshold, cfg_valid
    );

    modport slave (
        input  key_level, key_edge,
        output page, edit_mode, edit_value, threshold, cfg_valid
    );
endinterface

// File: rtl/button_menu_ctrl.sv
// rtl/button_menu_ctrl.sv - press classifier and page/edit/commit state machine for the panel menu
module button_menu_ctrl #(
    parameter int SYS_CLOCK   = 100_000_000,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int TIMEOUT_MS  = 10000,
    parameter int PAGE_NUM    = 4,
    parameter int VALUE_WIDTH = 8,
    parameter int VALUE_MIN   = 0,
    parameter int VALUE_MAX   = 100,
    parameter int VALUE_INIT  = 50
) (
    input  logic               clk,
    input  logic               rst,
    button_menu_ctrl_if.slave  bus
);
    localparam int CPM    = SYS_CLOCK / 1000;
    localparam int LONG_T = LONG_MS * CPM - 1;
    localparam int REP_T  = REPEAT_MS * CPM - 1;
    localparam int TO_T   = TIMEOUT_MS * CPM - 1;
    localparam int HOLD_W = (LONG_T > 0) ? $clog2(LONG_T + 1) : 1;
    localparam int REP_W  = (REP_T > 0) ? $clog2(REP_T + 1) : 1;
    localparam int TO_W   = (TO_T > 0) ? $clog2(TO_T + 1) : 1;
    localparam int PAGE_W = (PAGE_NUM > 1) ? $clog2(PAGE_NUM) : 1;

    localparam logic [1:0] S_VIEW   = 2'd0;
    localparam logic [1:0] S_EDIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [HOLD_W-1:0]      HOLD_TERM = HOLD_W'(LONG_T);
    localparam logic [REP_W-1:0]       REP_TERM  = REP_W'(REP_T);
    localparam logic [TO_W-1:0]        TO_TERM   = TO_W'(TO_T);
    localparam logic [PAGE_W-1:0]      PAGE_LAST = PAGE_W'(PAGE_NUM - 1);
    localparam logic [VALUE_WIDTH-1:0] V_MIN     = VALUE_WIDTH'(VALUE_MIN);
    localparam logic [VALUE_WIDTH-1:0] V_MAX     = VALUE_WIDTH'(VALUE_MAX);
    localparam logic [VALUE_WIDTH-1:0] V_INIT    = VALUE_WIDTH'(VALUE_INIT);

    logic [1:0]              state;
    logic [HOLD_W-1:0]       hold_cnt [2];
    logic [1:0]              prev_level;
    logic [1:0]              armed;
    logic [1:0]              long_flag;
    logic [1:0]              ev_short;
    logic [1:0]              ev_long;
    logic                    rep_active;
    logic [REP_W-1:0]        rep_cnt;
    logic                    ev_rep;
    logic [TO_W-1:0]         to_cnt;
    logic                    timeout;
    logic                    any_evt;
    logic                    inc_evt;
    logic [VALUE_WIDTH-1:0]  inc_value;

    // A press is armed only by an edge that follows a low level, so a key held
    // through reset (or a spurious edge) never produces SHORT/LONG.
    always_comb begin
        ev_short = '0;
        ev_long  = '0;
        for (int k = 0; k < 2; k++) begin
            ev_long[k]  = armed[k] & bus.key_level[k] & ~long_flag[k] & (hold_cnt[k] == HOLD_TERM);
            ev_short[k] = armed[k] & prev_level[k] & ~bus.key_level[k] & ~long_flag[k];
        end
    end

    assign ev_rep    = rep_active & bus.key_level[1] & (state == S_EDIT) & (rep_cnt == REP_TERM);
    assign timeout   = (state == S_EDIT) & (to_cnt == TO_TERM);
    assign any_evt   = (|bus.key_edge) | (|ev_short) | (|ev_long) | ev_rep;
    assign inc_evt   = ev_short[1] | ev_long[1] | ev_rep;
    assign inc_value = (bus.edit_value >= V_MAX) ? V_MIN : bus.edit_value + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt[0] <= '0;
            hold_cnt[1] <= '0;
            prev_level  <= '0;
            armed       <= '0;
            long_flag   <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                prev_level[k] <= bus.key_level[k];
                if (bus.key_edge[k])
                    hold_cnt[k] <= '0;
                else if (bus.key_level[k] && hold_cnt[k] != HOLD_TERM)
                    hold_cnt[k] <= hold_cnt[k] + 1'b1;
                if (bus.key_edge[k] && !prev_level[k])
                    armed[k] <= 1'b1;
                else if (!bus.key_level[k])
                    armed[k] <= 1'b0;
                if (!bus.key_level[k])
                    long_flag[k] <= 1'b0;
                else if (ev_long[k])
                    long_flag[k] <= 1'b1;
            end
        end
    end

    // Auto-repeat starts one full period after the INC LONG in EDIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_active <= 1'b0;
            rep_cnt    <= '0;
        end else if (state != S_EDIT || !bus.key_level[1]) begin
            rep_active <= 1'b0;
            rep_cnt    <= '0;
        end else if (ev_long[1]) begin
            rep_active <= 1'b1;
            rep_cnt    <= '0;
        end else if (rep_active) begin
            rep_cnt <= ev_rep ? '0 : rep_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state != S_EDIT || any_evt || timeout)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    // SEL events win over INC events; timeout wins over an INC increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_VIEW;
            bus.page       <= '0;
            bus.edit_mode  <= 1'b0;
            bus.edit_value <= V_INIT;
            bus.threshold  <= V_INIT;
            bus.cfg_valid  <= 1'b0;
        end else begin
            bus.cfg_valid <= 1'b0;
            case (state)
                S_VIEW: begin
                    if (ev_short[0]) begin
                        bus.page <= (bus.page == PAGE_LAST) ? '0 : bus.page + 1'b1;
                    end else if (ev_long[0]) begin
                        state          <= S_EDIT;
                        bus.edit_mode  <= 1'b1;
                        bus.edit_value <= bus.threshold;
                    end
                end
                S_EDIT: begin
                    if (ev_short[0]) begin
                        state <= S_COMMIT;
                    end else if (ev_long[0] || timeout) begin
                        state          <= S_VIEW;
                        bus.edit_mode  <= 1'b0;
                        bus.edit_value <= bus.threshold;
                    end else if (inc_evt) begin
                        bus.edit_value <= inc_value;
                    end
                end
                S_COMMIT: begin
                    bus.threshold <= bus.edit_value;
                    bus.cfg_valid <= 1'b1;
                    bus.edit_mode <= 1'b0;
                    state         <= S_VIEW;
                end
                default: begin
                    state <= S_VIEW;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_menu_ctrl.sv
// tb/tb_button_menu_ctrl.sv - directed self-checking bench for button_menu_ctrl
module tb_button_menu_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cfg_cnt = 0;
    int   c0;
    int   n;

    always #5 clk = ~clk;

    button_menu_ctrl_if #(.PAGE_NUM(4), .VALUE_WIDTH(8)) bus ();

    button_menu_ctrl #(
        .SYS_CLOCK  (10_000),
        .LONG_MS    (10),
        .REPEAT_MS  (5),
        .TIMEOUT_MS (50),
        .PAGE_NUM   (4),
        .VALUE_WIDTH(8),
        .VALUE_MIN  (0),
        .VALUE_MAX  (100),
        .VALUE_INIT (50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) if (bus.cfg_valid === 1'b1) cfg_cnt++;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int cycles);
        bus.key_level[k] = 1'b1;
        bus.key_edge[k]  = 1'b1;
        tick();
        bus.key_edge[k]  = 1'b0;
        repeat (cycles - 1) tick();
    endtask

    task automatic release_key(input int k);
        bus.key_level[k] = 1'b0;
        tick();
    endtask

    task automatic short_press(input int k);
        press(k, 3);
        release_key(k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.key_level = 2'b00;
        bus.key_edge  = 2'b00;
        repeat (3) tick();
        check("rst_page", bus.page, 0);
        check("rst_edit_mode", bus.edit_mode, 0);
        check("rst_edit_value", bus.edit_value, 50);
        check("rst_threshold", bus.threshold, 50);
        check("rst_cfg_valid", bus.cfg_valid, 0);
        rst = 1'b0;
        repeat (2) tick();

        // page wrap in VIEW
        for (int i = 0; i < 4; i++) begin
            press(0, 20);
            check("page_hold", bus.page, i);
            release_key(0);
            check("page_wrap", bus.page, (i + 1) % 4);
            repeat (3) tick();
        end
        check("page_no_cfg", cfg_cnt, 0);

        // long SEL into EDIT
        press(0, 100);
        check("long_t100", bus.edit_mode, 0);
        tick();
        check("long_t101", bus.edit_mode, 1);
        check("long_edit_value", bus.edit_value, 50);
        repeat (49) tick();
        release_key(0);
        repeat (3) tick();
        check("long_no_short", bus.edit_mode, 1);
        check("long_page_kept", bus.page, 0);

        // three INC shorts then commit
        for (int i = 1; i <= 3; i++) begin
            press(1, 20);
            release_key(1);
            check("inc_short", bus.edit_value, 50 + i);
        end
        c0 = cfg_cnt;
        press(0, 20);
        release_key(0);
        check("commit_pre_thr", bus.threshold, 50);
        check("commit_pre_cfg", bus.cfg_valid, 0);
        check("commit_pre_mode", bus.edit_mode, 1);
        tick();
        check("commit_thr", bus.threshold, 53);
        check("commit_cfg", bus.cfg_valid, 1);
        check("commit_mode", bus.edit_mode, 0);
        tick();
        check("commit_cfg_end", bus.cfg_valid, 0);
        check("commit_one_pulse", cfg_cnt, c0 + 1);

        // auto-repeat and wrap to VALUE_MIN
        press(0, 110);
        release_key(0);
        check("reenter_value", bus.edit_value, 53);
        repeat (45) short_press(1);
        check("rep_start", bus.edit_value, 98);
        press(1, 100);
        check("rep_t100", bus.edit_value, 98);
        tick();
        check("rep_long", bus.edit_value, 99);
        repeat (50) tick();
        check("rep_first", bus.edit_value, 100);
        repeat (50) tick();
        check("rep_wrap", bus.edit_value, 0);
        repeat (19) tick();
        release_key(1);
        check("rep_release", bus.edit_value, 0);
        check("rep_still_edit", bus.edit_mode, 1);

        // cancel with SEL long
        repeat (60) short_press(1);
        check("cancel_set", bus.edit_value, 60);
        press(0, 101);
        check("cancel_mode", bus.edit_mode, 0);
        check("cancel_value", bus.edit_value, 53);
        check("cancel_thr", bus.threshold, 53);
        repeat (9) tick();
        release_key(0);

        // inactivity timeout
        c0 = cfg_cnt;
        press(0, 110);
        release_key(0);
        check("to_enter", bus.edit_mode, 1);
        short_press(1);
        check("to_inc", bus.edit_value, 54);
        n = 0;
        while (bus.edit_mode && n < 700) begin
            tick();
            n++;
        end
        check("to_cycles", n, 500);
        check("to_value", bus.edit_value, 53);
        check("to_thr", bus.threshold, 53);
        check("to_no_cfg", cfg_cnt, c0);

        // SEL and INC released together: commit wins, no increment
        press(0, 110);
        release_key(0);
        short_press(1);
        check("prio_pre", bus.edit_value, 54);
        c0 = cfg_cnt;
        bus.key_level = 2'b11;
        bus.key_edge  = 2'b11;
        tick();
        bus.key_edge  = 2'b00;
        repeat (4) tick();
        bus.key_level = 2'b00;
        tick();
        check("prio_no_inc", bus.edit_value, 54);
        tick();
        check("prio_thr", bus.threshold, 54);
        check("prio_cfg", bus.cfg_valid, 1);
        tick();
        check("prio_one_pulse", cfg_cnt, c0 + 1);

        // reset mid-hold in EDIT
        short_press(0);
        check("rsthold_page", bus.page, 1);
        press(0, 110);
        check("rsthold_edit", bus.edit_mode, 1);
        rst = 1'b1;
        #1;
        check("rsthold_page0", bus.page, 0);
        check("rsthold_mode0", bus.edit_mode, 0);
        check("rsthold_value", bus.edit_value, 50);
        check("rsthold_thr", bus.threshold, 50);
        check("rsthold_cfg", bus.cfg_valid, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (150) tick();
        check("rsthold_no_long", bus.edit_mode, 0);
        release_key(0);
        tick();
        check("rsthold_no_short", bus.page, 0);
        short_press(0);
        check("rsthold_new_edge", bus.page, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
